// File: rtl/sram_responder.sv
// Word-organised SRAM responder: 1-cycle reads, byte-lane writes, range check, preload port, stats.
// Latency: read data (or 0 for out-of-range) appears on sram_rdata one posedge after the request.
// Backpressure: none; every request is accepted in its cycle, and idle cycles hold sram_rdata.
module sram_responder #(
  parameter int          DEPTH     = 4096,
  parameter int          IDX_W     = 12,
  parameter logic [31:0] BASE_ADDR = 32'h1c000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sram_en,
  input  logic [3:0]       sram_we,
  input  logic [31:0]      sram_addr,
  input  logic [31:0]      sram_wdata,
  output logic [31:0]      sram_rdata,
  input  logic             ld_en,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [31:0]      ld_data,
  output logic [15:0]      rd_cnt,
  output logic [15:0]      wr_cnt,
  output logic [15:0]      oob_cnt,
  output logic [15:0]      misalign_cnt
);

  // Memory contents survive reset on purpose: the preload must outlive a core reset.
  logic [31:0] mem [DEPTH];

  // BASE_ADDR is word aligned, so the word offset can be taken from the upper address
  // bits directly; the 30-bit subtraction wraps just like the full byte offset would,
  // which sends addresses below BASE to huge indices and hence out of range.
  logic [29:0]      widx;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             misaligned;
  logic             is_write;

  // Decode the request: word index, range check, alignment and access kind.
  always_comb begin
    widx       = sram_addr[31:2] - BASE_ADDR[31:2];
    idx        = widx[IDX_W-1:0];
    in_range   = (widx < 30'(DEPTH));
    misaligned = (sram_addr[1:0] != 2'b00);
    is_write   = (sram_we != 4'h0);
  end

  // Array update: sram byte lanes first, then preload, so a same-index preload wins on every lane.
  always_ff @(posedge clk) begin
    if (sram_en && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_we[i]) begin
          mem[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
      end
    end
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
  end

  // Read-first response register: old word for in-range reads and writes, zero when out of range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_rdata <= 32'h0;
    end else if (sram_en) begin
      sram_rdata <= in_range ? mem[idx] : 32'h0;
    end
  end

  // Independent saturating access statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt       <= 16'h0;
      wr_cnt       <= 16'h0;
      oob_cnt      <= 16'h0;
      misalign_cnt <= 16'h0;
    end else if (sram_en) begin
      if (in_range && !is_write && rd_cnt != 16'hFFFF) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
      if (in_range && is_write && wr_cnt != 16'hFFFF) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
      if (!in_range && oob_cnt != 16'hFFFF) begin
        oob_cnt <= oob_cnt + 16'd1;
      end
      if (misaligned && misalign_cnt != 16'hFFFF) begin
        misalign_cnt <= misalign_cnt + 16'd1;
      end
    end
  end

endmodule
